score_display_scan: RTL and testbench

Controller sequencing the four-digit multiplexed seven-segment score display of the Pong CPLD. Accepts two binary player scores through a valid/ready handshake, converts each to two BCD digits with a sequential subtract-by-ten engine, commits all four digits atomically, and time-multiplexes them onto one shared segment bus with active-low digit enables. It sits between game logic (score source) and the display pins.

---
 rtl/score_display_scan_pkg.sv | 32 +++
 rtl/score_display_scan_sevenseg.sv | 30 +++
 rtl/score_display_scan.sv | 184 ++++++++++++++++++
 tb/tb_score_display_scan.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_scan_pkg.sv
// ----------------------------------------------------------------------------
// score_display_scan_pkg
// Shared definitions for the Pong score display controller:
//   - conversion FSM state encoding
//   - blank BCD code (decodes to all segments off)
//   - score clamp limit and the subtract step of the BCD engine
//   - digit-index constants (index 0 is the leftmost digit, A tens)
//   - clamp_score(): saturates a 7-bit binary score to 99
// ----------------------------------------------------------------------------
package score_display_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_A = 2'd1,
        CONV_B = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [6:0] SCORE_MAX  = 7'd99;
    localparam logic [6:0] DEC_STEP   = 7'd10;

    localparam logic [1:0] DIGIT_A_TENS  = 2'd0;
    localparam logic [1:0] DIGIT_A_UNITS = 2'd1;
    localparam logic [1:0] DIGIT_B_TENS  = 2'd2;
    localparam logic [1:0] DIGIT_B_UNITS = 2'd3;

    function automatic logic [6:0] clamp_score(input logic [6:0] score);
        return (score > SCORE_MAX) ? SCORE_MAX : score;
    endfunction

endpackage

// File: rtl/score_display_scan_sevenseg.sv
// ----------------------------------------------------------------------------
// SevenSeg
// Combinational BCD to seven-segment decoder, active-high segments.
// Ports:
//   bcd [3:0]  digit code; 0-9 decode normally, anything above 9 is blank
//   out [6:0]  segments a..g, out[6] = a
// ----------------------------------------------------------------------------
module SevenSeg (
    input  logic [3:0] bcd,
    output logic [6:0] out
);

    always_comb begin
        out = 7'b0000000;
        case (bcd)
            4'd0: out = 7'b1111110;
            4'd1: out = 7'b0110000;
            4'd2: out = 7'b1101101;
            4'd3: out = 7'b1111001;
            4'd4: out = 7'b0110011;
            4'd5: out = 7'b1011011;
            4'd6: out = 7'b1011111;
            4'd7: out = 7'b1110000;
            4'd8: out = 7'b1111111;
            4'd9: out = 7'b1111011;
            default: out = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/score_display_scan.sv
// ----------------------------------------------------------------------------
// score_display_scan
// Four-digit multiplexed seven-segment score display controller.
// Two binary scores are accepted through load/ready, converted to BCD by a
// sequential subtract-by-ten engine, committed to the display registers in a
// single edge, and scanned onto one shared segment bus.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (2..65535)
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load         request to take new scores, accepted when load && ready
//   score_a[6:0] player A binary score (clamped to 99)
//   score_b[6:0] player B binary score (clamped to 99)
//   ready        high only while the converter is idle
//   seg[6:0]     segments a..g, active-high, seg[6] = a
//   an[3:0]      active-low digit enables, registered;
//                an[3] A tens, an[2] A units, an[1] B tens, an[0] B units
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is stored blank
// ----------------------------------------------------------------------------
module score_display_scan
    import score_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] score_a,
    input  logic [6:0] score_b,
    output logic       ready,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

    state_t          state;
    state_t          state_next;
    logic [6:0]      rem_a;
    logic [6:0]      rem_b;
    logic [3:0]      tens;
    logic [3:0][3:0] shadow;
    logic [3:0][3:0] display;

    logic [15:0]     presc;
    logic [15:0]     presc_next;
    logic [1:0]      index;
    logic [1:0]      index_next;
    logic [3:0]      an_next;

    // Tens digit as stored in the shadow registers.
    function automatic logic [3:0] tens_code(input logic [3:0] t);
`ifdef LEADING_ZERO_BLANK_EN
        return (t == 4'd0) ? BLANK_CODE : t;
`else
        return t;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each conversion state holds until its remainder drops below ten.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    state_next = CONV_A;
                end
            end
            CONV_A: begin
                if (rem_a < DEC_STEP) begin
                    state_next = CONV_B;
                end
            end
            CONV_B: begin
                if (rem_b < DEC_STEP) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Binary-to-BCD engine: the tens counter is shared by both scores and
    // cleared whenever one score finishes. Digits collect in shadow registers
    // so the visible display only changes on the COMMIT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_a   <= '0;
            rem_b   <= '0;
            tens    <= '0;
            shadow  <= '0;
            display <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        rem_a <= clamp_score(score_a);
                        rem_b <= clamp_score(score_b);
                        tens  <= 4'd0;
                    end
                end
                CONV_A: begin
                    if (rem_a >= DEC_STEP) begin
                        rem_a <= rem_a - DEC_STEP;
                        tens  <= tens + 4'd1;
                    end else begin
                        shadow[DIGIT_A_TENS]  <= tens_code(tens);
                        shadow[DIGIT_A_UNITS] <= rem_a[3:0];
                        tens                  <= 4'd0;
                    end
                end
                CONV_B: begin
                    if (rem_b >= DEC_STEP) begin
                        rem_b <= rem_b - DEC_STEP;
                        tens  <= tens + 4'd1;
                    end else begin
                        shadow[DIGIT_B_TENS]  <= tens_code(tens);
                        shadow[DIGIT_B_UNITS] <= rem_b[3:0];
                        tens                  <= 4'd0;
                    end
                end
                COMMIT: begin
                    display <= shadow;
                end
                default: begin
                end
            endcase
        end
    end

    // Scan sequencing. The enable pattern is derived from the values the
    // prescaler and index are about to take, so the registered an lines up
    // with the slot: all-off on the slot's first cycle, one enable afterwards.
    always_comb begin
        if (presc == PRESC_LAST) begin
            presc_next = 16'd0;
            index_next = index + 2'd1;
        end else begin
            presc_next = presc + 16'd1;
            index_next = index;
        end
        if (presc_next == 16'd0) begin
            an_next = 4'b1111;
        end else begin
            an_next = ~(4'b1000 >> index_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            index <= '0;
            an    <= 4'b1111;
        end else begin
            presc <= presc_next;
            index <= index_next;
            an    <= an_next;
        end
    end

    SevenSeg u_seven_seg (
        .bcd (display[index]),
        .out (seg)
    );

endmodule

// File: tb/tb_score_display_scan.sv
// ----------------------------------------------------------------------------
// tb_score_display_scan
// Self-checking bench for score_display_scan with REFRESH_DIV = 4.
// Expected values come from an arithmetic model: scan position is derived from
// the number of clock edges since reset, digits from integer divide/modulo of
// the clamped scores, and busy time from floor(a/10) + floor(b/10) + 3.
// ----------------------------------------------------------------------------
module tb_score_display_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [6:0] score_a;
    logic [6:0] score_b;
    logic       ready;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;
    int scan_t;

    always #5 clk = ~clk;

    score_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .score_a (score_a),
        .score_b (score_b),
        .ready   (ready),
        .seg     (seg),
        .an      (an)
    );

    // Clock edges elapsed since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scan_t <= 0;
        else        scan_t <= scan_t + 1;
    end

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int digit_of(int a, int b, int pos);
        int ca = (a > 99) ? 99 : a;
        int cb = (b > 99) ? 99 : b;
        int d;
        case (pos)
            0: d = ca / 10;
            1: d = ca % 10;
            2: d = cb / 10;
            default: d = cb % 10;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((pos == 0 || pos == 2) && d == 0) d = 15;
`endif
        return d;
    endfunction

    function automatic int latency(int a, int b);
        int ca = (a > 99) ? 99 : a;
        int cb = (b > 99) ? 99 : b;
        return ca / 10 + cb / 10 + 3;
    endfunction

    function automatic logic [3:0] exp_an(int t);
        if (t % DIV == 0) return 4'b1111;
        case ((t / DIV) % 4)
            0: return 4'b0111;
            1: return 4'b1011;
            2: return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int a, int b, int t);
        return seg_of(digit_of(a, b, (t / DIV) % 4));
    endfunction

    // Waits for ready, presents one accepted load, scrambles the inputs after
    // the accept edge and measures how many cycles ready stays low.
    task automatic drive_accept(input int a, input int b, output int low_cycles);
        int guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        score_a = 7'(a);
        score_b = 7'(b);
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        score_a = 7'($urandom);
        score_b = 7'($urandom);
        low_cycles = 0;
        while (ready !== 1'b1 && low_cycles < 200) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        load    = 1'b0;
        score_a = '0;
        score_b = '0;
        #12;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: got %b expected 1111", an); end
        checks++;
        if (seg !== seg_of(0)) begin errors++; $display("[TB] FAIL reset_seg: got %b expected %b", seg, seg_of(0)); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_first_slot_an: got %b expected 1111", an); end
        for (int i = 0; i < 4 * DIV + 4; i++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an(scan_t)) begin errors++; $display("[TB] FAIL reset_scan_an t=%0d: got %b expected %b", scan_t, an, exp_an(scan_t)); end
            checks++;
            if (seg !== seg_of(0)) begin errors++; $display("[TB] FAIL reset_scan_seg t=%0d: got %b expected %b", scan_t, seg, seg_of(0)); end
            checks++;
            if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_ready: got %b expected 1", ready); end
        end
    endtask

    task automatic test_load_pair(input int a, input int b, input string name);
        int low;
        drive_accept(a, b, low);
        checks++;
        if (low !== latency(a, b)) begin errors++; $display("[TB] FAIL %s_latency a=%0d b=%0d: got %0d expected %0d", name, a, b, low, latency(a, b)); end
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            checks++;
            if (seg !== exp_seg(a, b, scan_t)) begin errors++; $display("[TB] FAIL %s_seg a=%0d b=%0d t=%0d: got %b expected %b", name, a, b, scan_t, seg, exp_seg(a, b, scan_t)); end
            checks++;
            if (an !== exp_an(scan_t)) begin errors++; $display("[TB] FAIL %s_an t=%0d: got %b expected %b", name, scan_t, an, exp_an(scan_t)); end
        end
    endtask

    task automatic test_random_loads;
        for (int n = 0; n < 6; n++) begin
            test_load_pair(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), "random");
        end
    endtask

    task automatic test_ignored_load;
        int low = 0;
        int k = 1;
        int guard = 0;
        while (ready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
        score_a = 7'd63;
        score_b = 7'd28;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        while (ready !== 1'b1 && low < 200) begin
            low++;
            if (k == 2) begin
                load    = 1'b1;
                score_a = 7'd1;
                score_b = 7'd1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        load = 1'b0;
        checks++;
        if (low !== latency(63, 28)) begin errors++; $display("[TB] FAIL ignored_latency: got %0d expected %0d", low, latency(63, 28)); end
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            checks++;
            if (seg !== exp_seg(63, 28, scan_t)) begin errors++; $display("[TB] FAIL ignored_seg t=%0d: got %b expected %b", scan_t, seg, exp_seg(63, 28, scan_t)); end
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ignored_no_requeue: got ready %b expected 1", ready); end
    endtask

    task automatic test_reset_mid_conv;
        int low;
        int guard = 0;
        while (ready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
        score_a = 7'd55;
        score_b = 7'd55;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", ready); end
        checks++;
        if (an !== 4'b1111) begin errors++; $display("[TB] FAIL midreset_an: got %b expected 1111", an); end
        checks++;
        if (seg !== seg_of(0)) begin errors++; $display("[TB] FAIL midreset_seg: got %b expected %b", seg, seg_of(0)); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            checks++;
            if (seg !== seg_of(0)) begin errors++; $display("[TB] FAIL midreset_display t=%0d: got %b expected %b", scan_t, seg, seg_of(0)); end
            checks++;
            if (an !== exp_an(scan_t)) begin errors++; $display("[TB] FAIL midreset_an_scan t=%0d: got %b expected %b", scan_t, an, exp_an(scan_t)); end
        end
        drive_accept(3, 4, low);
        checks++;
        if (low !== latency(3, 4)) begin errors++; $display("[TB] FAIL midreset_reload_latency: got %0d expected %0d", low, latency(3, 4)); end
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            checks++;
            if (seg !== exp_seg(3, 4, scan_t)) begin errors++; $display("[TB] FAIL midreset_reload_seg t=%0d: got %b expected %b", scan_t, seg, exp_seg(3, 4, scan_t)); end
        end
    endtask

    task automatic test_back_to_back;
        int acc_a[$];
        int acc_b[$];
        int accepts = 0;
        int lowcnt = 0;
        int cycles = 0;
        int a;
        int b;
        while (cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (ready === 1'b1) begin
                if (accepts > 0) begin
                    checks++;
                    if (lowcnt !== latency(acc_a[$], acc_b[$])) begin errors++; $display("[TB] FAIL b2b_latency #%0d: got %0d expected %0d", accepts, lowcnt, latency(acc_a[$], acc_b[$])); end
                    checks++;
                    if (seg !== exp_seg(acc_a[$], acc_b[$], scan_t)) begin errors++; $display("[TB] FAIL b2b_commit #%0d: got %b expected %b", accepts, seg, exp_seg(acc_a[$], acc_b[$], scan_t)); end
                end
                if (accepts == 5) begin
                    load = 1'b0;
                    break;
                end
                a = int'($urandom_range(0, 127));
                b = int'($urandom_range(0, 127));
                score_a = 7'(a);
                score_b = 7'(b);
                load    = 1'b1;
                acc_a.push_back(a);
                acc_b.push_back(b);
                accepts++;
                lowcnt = 0;
            end else begin
                lowcnt++;
                score_a = 7'($urandom);
                score_b = 7'($urandom);
            end
        end
        load = 1'b0;
        checks++;
        if (accepts !== 5) begin errors++; $display("[TB] FAIL b2b_accept_count: got %0d expected 5", accepts); end
        if (accepts > 0) begin
            for (int i = 0; i < 4 * DIV; i++) begin
                @(negedge clk);
                checks++;
                if (seg !== exp_seg(acc_a[$], acc_b[$], scan_t)) begin errors++; $display("[TB] FAIL b2b_final_seg t=%0d: got %b expected %b", scan_t, seg, exp_seg(acc_a[$], acc_b[$], scan_t)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_pair(42, 7, "basic");
        test_load_pair(120, 99, "clamp");
        test_load_pair(0, 100, "zero_clamp");
        test_random_loads();
        test_ignored_load();
        test_reset_mid_conv();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
